// File: rtl/bsg_adder_pkg.sv
// Shared definitions for the carry-save resolver.
// Holds the control-state type and a clog2 helper that never returns zero.
package bsg_adder_pkg;

  typedef enum logic [1:0] {
    eIdle,
    eBusy,
    eDone
  } bsg_adder_state_e;

  // Counter width helper: a single-chunk configuration still needs a 1-bit counter.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_adder_chunk_carry.sv
// chunk_p-bit ripple adder with carry-in and carry-out.
// Ports:
//   a_i, b_i  chunk operands
//   c_i       carry into bit 0
//   sum_o     chunk sum
//   c_o       carry out of the top bit
module bsg_adder_chunk_carry #(
  parameter int chunk_p = 8
) (
  input  logic [chunk_p-1:0] a_i,
  input  logic [chunk_p-1:0] b_i,
  input  logic               c_i,
  output logic [chunk_p-1:0] sum_o,
  output logic               c_o
);

  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{chunk_p{1'b0}}, c_i};

endmodule

// File: rtl/bsg_adder_carry_save_resolver.sv
// Resolves a carry-save (resA, resB) pair into a binary sum, chunk_p bits
// per cycle, so the full-width carry chain never sits on one timing path.
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   v_i, ready_o     operand handshake (valid/ready)
//   resA_i, resB_i   carry-save operands
//   v_o, yumi_i      result handshake (valid/yumi)
//   sum_o            (A+B) mod 2^width_p, meaningful while v_o=1
//   carry_o          carry out of bit width_p-1
module bsg_adder_carry_save_resolver
  import bsg_adder_pkg::*;
#(
  parameter int width_p = 32,
  parameter int chunk_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] resA_i,
  input  logic [width_p-1:0] resB_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] sum_o,
  output logic               carry_o
);

  localparam int num_chunks_lp = width_p / chunk_p;
  localparam int cnt_w_lp      = safe_clog2(num_chunks_lp);

  if ((width_p % chunk_p) != 0) begin : g_bad_chunk
    $error("bsg_adder_carry_save_resolver: width_p (%0d) must be a multiple of chunk_p (%0d)",
           width_p, chunk_p);
  end

  bsg_adder_state_e state_q, state_d;

  logic [cnt_w_lp-1:0] cnt_q;
  logic [width_p-1:0]  a_q, b_q, sum_q;
  logic                carry_q;
  logic                carry_out_q;

  logic                load, step, last;
  logic                ready_raw, valid_raw;
  logic [chunk_p-1:0]  a_sel, b_sel, s_chunk;
  logic                c_chunk;

  assign last = (cnt_q == cnt_w_lp'(num_chunks_lp - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= eIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    ready_raw = 1'b0;
    valid_raw = 1'b0;
    unique case (state_q)
      eIdle: begin
        ready_raw = 1'b1;
        if (v_i) begin
          load    = 1'b1;
          state_d = eBusy;
        end
      end
      eBusy: begin
        step = 1'b1;
        if (last) state_d = eDone;
      end
      eDone: begin
        valid_raw = 1'b1;
        // Taking the result frees the slot in the same cycle, allowing back-to-back ops.
        ready_raw = yumi_i;
        if (yumi_i) begin
          load    = v_i;
          state_d = v_i ? eBusy : eIdle;
        end
      end
      default: state_d = eIdle;
    endcase
  end

  assign ready_o = ready_raw & ~reset_i;
  assign v_o     = valid_raw;
  assign sum_o   = sum_q;
  assign carry_o = carry_out_q;

  // Select the chunk addressed by the counter.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < num_chunks_lp; i++) begin
      if (cnt_q == cnt_w_lp'(i)) begin
        a_sel = a_q[i*chunk_p +: chunk_p];
        b_sel = b_q[i*chunk_p +: chunk_p];
      end
    end
  end

  bsg_adder_chunk_carry #(
    .chunk_p(chunk_p)
  ) u_chunk (
    .a_i   (a_sel),
    .b_i   (b_sel),
    .c_i   (carry_q),
    .sum_o (s_chunk),
    .c_o   (c_chunk)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
    end else if (load) begin
      a_q     <= resA_i;
      b_q     <= resB_i;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (step) begin
      for (int unsigned i = 0; i < num_chunks_lp; i++) begin
        if (cnt_q == cnt_w_lp'(i)) sum_q[i*chunk_p +: chunk_p] <= s_chunk;
      end
      carry_q <= c_chunk;
      if (last) begin
        cnt_q       <= '0;
        carry_out_q <= c_chunk;
      end else begin
        cnt_q <= cnt_q + cnt_w_lp'(1);
      end
    end
  end

endmodule

// File: tb/tb_bsg_adder_carry_save_resolver.sv
module tb_bsg_adder_carry_save_resolver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v, yumi;
  logic [35:0] a, b;
  int          sel;

  int checks = 0;
  int errors = 0;
  bit allow_illegal = 1'b0;

  // Three configurations: (32,8), (32,32), (36,4)
  logic        v0, v1, v2, y0, y1, y2;
  logic        rdy0, rdy1, rdy2, vo0, vo1, vo2, co0, co1, co2;
  logic [31:0] sum0, sum1;
  logic [35:0] sum2;

  assign v0 = v && (sel == 0);
  assign v1 = v && (sel == 1);
  assign v2 = v && (sel == 2);
  assign y0 = yumi && (sel == 0);
  assign y1 = yumi && (sel == 1);
  assign y2 = yumi && (sel == 2);

  bsg_adder_carry_save_resolver #(.width_p(32), .chunk_p(8)) u_dut_32_8 (
    .clk_i(clk), .reset_i(rst), .v_i(v0), .ready_o(rdy0),
    .resA_i(a[31:0]), .resB_i(b[31:0]), .v_o(vo0), .yumi_i(y0),
    .sum_o(sum0), .carry_o(co0)
  );

  bsg_adder_carry_save_resolver #(.width_p(32), .chunk_p(32)) u_dut_32_32 (
    .clk_i(clk), .reset_i(rst), .v_i(v1), .ready_o(rdy1),
    .resA_i(a[31:0]), .resB_i(b[31:0]), .v_o(vo1), .yumi_i(y1),
    .sum_o(sum1), .carry_o(co1)
  );

  bsg_adder_carry_save_resolver #(.width_p(36), .chunk_p(4)) u_dut_36_4 (
    .clk_i(clk), .reset_i(rst), .v_i(v2), .ready_o(rdy2),
    .resA_i(a), .resB_i(b), .v_o(vo2), .yumi_i(y2),
    .sum_o(sum2), .carry_o(co2)
  );

  logic        vo, rdy, co;
  logic [35:0] cur_sum;

  always_comb begin
    vo = vo0; rdy = rdy0; co = co0; cur_sum = {4'b0, sum0};
    if (sel == 1) begin
      vo = vo1; rdy = rdy1; co = co1; cur_sum = {4'b0, sum1};
    end else if (sel == 2) begin
      vo = vo2; rdy = rdy2; co = co2; cur_sum = sum2;
    end
  end

  function automatic int cfg_w(input int s);
    return (s == 2) ? 36 : 32;
  endfunction

  function automatic int cfg_nc(input int s);
    return (s == 0) ? 4 : (s == 1) ? 1 : 9;
  endfunction

  // yumi without a valid result is never driven except in the dedicated test
  always @(posedge clk) begin
    if (!allow_illegal && yumi && !vo) begin
      errors++;
      $display("FAIL illegal_yumi: got yumi with v_o=%0b, expected v_o=1", vo);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cfg %0d): got %h, expected %h", name, sel, got, exp);
    end
  endtask

  // Called at the negedge right after the accept edge; counts edges until v_o.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!vo && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Called at a negedge; returns at a negedge with v_o=1 (or after timeout).
  task automatic run_op(input logic [35:0] ia, input logic [35:0] ib,
                        output logic [63:0] osum, output logic oc, output int lat);
    a = ia; b = ib; v = 1'b1;
    chk("ready_before_accept", {63'b0, rdy}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    v = 1'b0;
    wait_done(lat);
    osum = {28'b0, cur_sum};
    oc   = co;
  endtask

  task automatic take(input int hold);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
    end
    yumi = 1'b1;
    @(posedge clk);
    @(negedge clk);
    yumi = 1'b0;
  endtask

  task automatic verify_op(input string name, input logic [35:0] ia, input logic [35:0] ib,
                           input logic [63:0] esum, input logic ec, input int hold);
    logic [63:0] gs;
    logic        gc;
    int          lat;
    run_op(ia, ib, gs, gc, lat);
    chk({name, "_sum"}, gs, esum);
    chk({name, "_carry"}, {63'b0, gc}, {63'b0, ec});
    chk({name, "_latency"}, 64'(lat), 64'(cfg_nc(sel)));
    take(hold);
  endtask

  typedef struct {
    int          s;
    logic [35:0] va;
    logic [35:0] vb;
    logic [35:0] esum;
    logic        ecarry;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] gs, ref_full, mask;
    logic        gc;
    int          lat;

    vecs[0] = '{0, 36'hFFFFFFFF,  36'h1,         36'h0,         1'b1};
    vecs[1] = '{0, 36'h12345678,  36'h11111111,  36'h23456789,  1'b0};
    vecs[2] = '{0, 36'h80000000,  36'h80000000,  36'h0,         1'b1};
    vecs[3] = '{1, 36'hFFFFFFFF,  36'h1,         36'h0,         1'b1};
    vecs[4] = '{1, 36'h12345678,  36'h11111111,  36'h23456789,  1'b0};
    vecs[5] = '{2, 36'hFFFFFFFFF, 36'h1,         36'h0,         1'b1};
    vecs[6] = '{2, 36'h800000000, 36'h7FFFFFFFF, 36'hFFFFFFFFF, 1'b0};

    rst = 1'b1; v = 1'b0; yumi = 1'b0; a = '0; b = '0; sel = 0;
    repeat (2) @(negedge clk);

    // Reset state
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_ready", {63'b0, rdy}, 64'd0);
      chk("reset_v_o", {63'b0, vo}, 64'd0);
      chk("reset_sum", {28'b0, cur_sum}, 64'd0);
      chk("reset_carry", {63'b0, co}, 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("release_ready", {63'b0, rdy}, 64'd1);
    end

    // Directed vectors
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      sel = vecs[i].s;
      verify_op("vec", vecs[i].va, vecs[i].vb, {28'b0, vecs[i].esum}, vecs[i].ecarry, 0);
    end

    // Back-to-back: new pair accepted in the yumi cycle
    sel = 0;
    run_op(36'hFFFFFFFF, 36'h1, gs, gc, lat);
    chk("b2b_first_sum", gs, 64'd0);
    a = 36'h1; b = 36'h2; v = 1'b1; yumi = 1'b1;
    #1;
    chk("b2b_ready_with_yumi", {63'b0, rdy}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    v = 1'b0; yumi = 1'b0;
    chk("b2b_busy_v_o", {63'b0, vo}, 64'd0);
    chk("b2b_busy_ready", {63'b0, rdy}, 64'd0);
    wait_done(lat);
    chk("b2b_sum", {28'b0, cur_sum}, 64'd3);
    chk("b2b_carry", {63'b0, co}, 64'd0);
    chk("b2b_latency", 64'(lat), 64'd4);
    take(0);

    // Backpressure: result held, offered pair ignored
    run_op(36'h12345678, 36'h11111111, gs, gc, lat);
    for (int i = 0; i < 10; i++) begin
      v = 1'b1; a = 36'hAAAAAAAA; b = 36'h55555555;
      #1;
      chk("bp_ready", {63'b0, rdy}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("bp_v_o", {63'b0, vo}, 64'd1);
      chk("bp_sum", {28'b0, cur_sum}, 64'h23456789);
      chk("bp_carry", {63'b0, co}, 64'd0);
    end
    v = 1'b0;
    take(0);
    chk("bp_after_v_o", {63'b0, vo}, 64'd0);
    chk("bp_after_ready", {63'b0, rdy}, 64'd1);

    // yumi with no valid result is ignored
    allow_illegal = 1'b1;
    yumi = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("illegal_yumi_v_o", {63'b0, vo}, 64'd0);
      chk("illegal_yumi_ready", {63'b0, rdy}, 64'd1);
    end
    yumi = 1'b0;
    allow_illegal = 1'b0;
    verify_op("after_illegal", 36'h3, 36'h4, 64'd7, 1'b0, 0);

    // Async reset while a result is presented
    run_op(36'h3, 36'h4, gs, gc, lat);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_v_o_drop", {63'b0, vo}, 64'd0);
    chk("async_rst_ready", {63'b0, rdy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_rst_release_ready", {63'b0, rdy}, 64'd1);
    chk("async_rst_release_v_o", {63'b0, vo}, 64'd0);

    // Reset mid-operation at counter=2
    @(negedge clk);
    a = 36'hFFFFFFFF; b = 36'h1; v = 1'b1;
    @(posedge clk);
    #1 v = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midbusy_rst_v_o", {63'b0, vo}, 64'd0);
    chk("midbusy_rst_ready", {63'b0, rdy}, 64'd0);
    chk("midbusy_rst_sum", {28'b0, cur_sum}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      #1;
      chk("midbusy_no_stale_v_o", {63'b0, vo}, 64'd0);
      @(negedge clk);
    end
    verify_op("post_reset", 36'h5, 36'h7, 64'd12, 1'b0, 0);

    // Constrained-random vs plain-arithmetic golden model
    for (int s = 0; s < 3; s++) begin
      sel  = s;
      mask = (64'h1 << cfg_w(s)) - 64'h1;
      repeat (2000) begin
        logic [63:0] ra, rb;
        ra = {$urandom, $urandom} & mask;
        rb = {$urandom, $urandom} & mask;
        if ($urandom_range(0, 7) == 0) ra = mask;
        if ($urandom_range(0, 7) == 0) rb = mask;
        ref_full = ra + rb;
        verify_op("rand", ra[35:0], rb[35:0], ref_full & mask,
                  ref_full[cfg_w(s)], $urandom_range(0, 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
